// File: rtl/ahb_bus_checker.sv
// Passive AHB protocol checker: burst, control, wait-state and response rules.
// Ports: AHB address/control/response inputs, chk_en/err_clr; per-rule pulse, sticky, count, first-error capture.
module ahb_bus_checker #(
  parameter int ADDR_W  = 32,
  parameter int MST_W   = 4,
  parameter int CNT_W   = 16,
  parameter int KB_BITS = 10
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [MST_W-1:0]  hmaster,
  input  logic              chk_en,
  input  logic              err_clr,
  output logic [7:0]        err_pulse,
  output logic [7:0]        err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_valid,
  output logic [7:0]        first_code,
  output logic [ADDR_W-1:0] first_addr,
  output logic [MST_W-1:0]  first_master
);

  typedef enum logic {T_IDLE, T_BURST} trk_t;

  trk_t              state, state_nx;
  logic [3:0]        beats_q, beats_nx;
  logic              fixed_q, fixed_nx;
  logic              wr_q, wr_nx;
  logic [2:0]        sz_q, sz_nx;
  logic [2:0]        bu_q, bu_nx;
  logic [ADDR_W-1:0] prev_q, prev_nx;

  logic              p_wait;
  logic [1:0]        p_trans;
  logic [ADDR_W-1:0] p_addr;
  logic [1:0]        dp_trans;
  logic              resp_err_q;
  logic [ADDR_W-1:0] cap_addr;
  logic [MST_W-1:0]  cap_mst;

  logic              is_idle, is_busy, is_ns, is_seq;
  logic              acc, in_b, resp_bad, waive, hit;
  logic [ADDR_W-1:0] sz_b, incr_nx, wmask, wrap_exp;
  logic [4:0]        wbeats;
  logic [7:0]        viol;

  assign is_idle  = (htrans == 2'd0);
  assign is_busy  = (htrans == 2'd1);
  assign is_ns    = (htrans == 2'd2);
  assign is_seq   = (htrans == 2'd3);
  assign acc      = hready & htrans[1];
  assign in_b     = (state == T_BURST);
  assign resp_bad = (hresp != 2'd0);
  // an aborted burst is legal around a non-OKAY response
  assign waive    = resp_bad | resp_err_q;

  assign sz_b     = ADDR_W'(1) << hsize;
  assign incr_nx  = prev_q + sz_b;

  always_comb begin
    wbeats = 5'd0;
    unique case (bu_q[2:1])
      2'd1:    wbeats = 5'd4;
      2'd2:    wbeats = 5'd8;
      2'd3:    wbeats = 5'd16;
      default: wbeats = 5'd0;
    endcase
  end

  assign wmask    = (ADDR_W'(wbeats) << hsize) - ADDR_W'(1);
  assign wrap_exp = (prev_q & ~wmask) | (incr_nx & wmask);

  always_comb begin
    viol    = '0;
    viol[0] = acc & (|(haddr & (sz_b - ADDR_W'(1))));
    viol[1] = acc & is_seq & (haddr[KB_BITS-1:0] == '0);
    viol[2] = acc & is_seq & in_b & bu_q[0]
            & (haddr != incr_nx);
    viol[3] = acc & is_seq & in_b & ~bu_q[0]
            & (haddr != wrap_exp);
    viol[4] = (is_seq | is_busy) & in_b
            & ({hwrite, hsize, hburst} != {wr_q, sz_q, bu_q});
    viol[5] = hready & ~waive
            & (((is_seq | is_busy) & ~in_b)
            | (~htrans[0] & in_b & fixed_q & (beats_q != 4'd0)));
    viol[6] = p_wait & ~resp_bad
            & ((htrans != p_trans) | (haddr != p_addr));
    viol[7] = hready & ~dp_trans[1] & resp_bad;
  end

  always_comb begin
    state_nx = state;
    beats_nx = beats_q;
    fixed_nx = fixed_q;
    wr_nx    = wr_q;
    sz_nx    = sz_q;
    bu_nx    = bu_q;
    prev_nx  = prev_q;
    if (hready) begin
      unique case (1'b1)
        is_ns: begin
          if (hburst != 3'd0) begin
            state_nx = T_BURST;
            wr_nx    = hwrite;
            sz_nx    = hsize;
            bu_nx    = hburst;
            prev_nx  = haddr;
            fixed_nx = (hburst != 3'd1);
            if (hburst == 3'd1) beats_nx = 4'd0;
            else if (!hburst[2]) beats_nx = 4'd3;
            else beats_nx = hburst[1] ? 4'd15 : 4'd7;
          end else begin
            state_nx = T_IDLE;
          end
        end
        is_seq && in_b: begin
          prev_nx = haddr;
          if (fixed_q) begin
            beats_nx = beats_q - 4'd1;
            if (beats_q == 4'd1) state_nx = T_IDLE;
          end
        end
        is_idle: state_nx = T_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= T_IDLE;
      beats_q    <= '0;
      fixed_q    <= 1'b0;
      wr_q       <= 1'b0;
      sz_q       <= '0;
      bu_q       <= '0;
      prev_q     <= '0;
      p_wait     <= 1'b0;
      p_trans    <= '0;
      p_addr     <= '0;
      dp_trans   <= '0;
      resp_err_q <= 1'b0;
      cap_addr   <= '0;
      cap_mst    <= '0;
      err_pulse  <= '0;
    end else begin
      state      <= state_nx;
      beats_q    <= beats_nx;
      fixed_q    <= fixed_nx;
      wr_q       <= wr_nx;
      sz_q       <= sz_nx;
      bu_q       <= bu_nx;
      prev_q     <= prev_nx;
      p_wait     <= ~hready & htrans[1];
      p_trans    <= htrans;
      p_addr     <= haddr;
      if (hready) begin
        dp_trans   <= htrans;
        resp_err_q <= resp_bad;
      end
      cap_addr   <= haddr;
      cap_mst    <= hmaster;
      err_pulse  <= chk_en ? viol : '0;
    end
  end

  assign hit = |err_pulse;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_sticky   <= '0;
      err_count    <= '0;
      first_valid  <= 1'b0;
      first_code   <= '0;
      first_addr   <= '0;
      first_master <= '0;
    end else if (err_clr) begin
      // a pulse arriving with the clear survives it
      err_sticky   <= err_pulse;
      err_count    <= CNT_W'(hit);
      first_valid  <= hit;
      first_code   <= err_pulse;
      first_addr   <= hit ? cap_addr : '0;
      first_master <= hit ? cap_mst : '0;
    end else begin
      err_sticky <= err_sticky | err_pulse;
      if (hit && !(&err_count))
        err_count <= err_count + CNT_W'(1);
      if (hit && !first_valid) begin
        first_valid  <= 1'b1;
        first_code   <= err_pulse;
        first_addr   <= cap_addr;
        first_master <= cap_mst;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_checker.sv
// Directed vector bench for ahb_bus_checker.
// Table of single-cycle vectors plus hand sequences for capture/count/clear.
module tb_ahb_bus_checker;

  localparam int AW = 32;
  localparam int MW = 4;
  localparam int CW = 4;

  logic          hclk = 0;
  logic          hreset = 1;
  logic [AW-1:0] haddr = '0;
  logic [1:0]    htrans = '0;
  logic          hwrite = 0;
  logic [2:0]    hsize = 3'd2;
  logic [2:0]    hburst = '0;
  logic          hready = 1;
  logic [1:0]    hresp = '0;
  logic [MW-1:0] hmaster = '0;
  logic          chk_en = 1;
  logic          err_clr = 0;
  logic [7:0]    err_pulse, err_sticky, first_code;
  logic [CW-1:0] err_count;
  logic          first_valid;
  logic [AW-1:0] first_addr;
  logic [MW-1:0] first_master;

  int n_chk = 0;
  int n_fail = 0;

  ahb_bus_checker #(.ADDR_W(AW), .MST_W(MW), .CNT_W(CW),
                    .KB_BITS(10)) dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hready(hready), .hresp(hresp),
    .hmaster(hmaster), .chk_en(chk_en), .err_clr(err_clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .first_valid(first_valid),
    .first_code(first_code), .first_addr(first_addr),
    .first_master(first_master));

  always #5 hclk = ~hclk;

  typedef struct {
    bit         rst;
    logic [1:0] tr;
    logic [31:0] a;
    logic [2:0] bu;
    logic [7:0] exp;
    logic       rdy;
    logic [1:0] rsp;
    logic       wr;
    logic [2:0] sz;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit r, logic [1:0] t,
      logic [31:0] a, logic [2:0] b, logic [7:0] e,
      logic rdy = 1, logic [1:0] rs = 0,
      logic wr = 0, logic [2:0] sz = 2);
    vec_t x;
    x.rst = r; x.tr = t; x.a = a; x.bu = b; x.exp = e;
    x.rdy = rdy; x.rsp = rs; x.wr = wr; x.sz = sz;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge hclk);
    htrans = 0; hready = 1; hresp = 0; err_clr = 0;
    hreset = 1;
    @(negedge hclk);
    hreset = 0;
  endtask

  task automatic drive(logic [1:0] t, logic [31:0] a,
                       logic [2:0] b, logic [2:0] sz = 2);
    htrans = t; haddr = a; hburst = b; hsize = sz;
    hready = 1; hresp = 0; hwrite = 0;
    @(posedge hclk);
    #1;
  endtask

  localparam logic [1:0] ID = 0, BY = 1, NS = 2, SQ = 3;

  initial begin
    tv.push_back(v(1, NS, 32'h100, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h104, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h108, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h10C, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h110, 3, 8'h20));
    tv.push_back(v(1, NS, 32'h38, 2, 8'h00));
    tv.push_back(v(0, SQ, 32'h3C, 2, 8'h00));
    tv.push_back(v(0, SQ, 32'h30, 2, 8'h00));
    tv.push_back(v(0, SQ, 32'h34, 2, 8'h00));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h00));
    tv.push_back(v(0, NS, 32'h38, 2, 8'h00));
    tv.push_back(v(0, SQ, 32'h3C, 2, 8'h00));
    tv.push_back(v(0, SQ, 32'h40, 2, 8'h08));
    tv.push_back(v(0, SQ, 32'h44, 2, 8'h00));
    tv.push_back(v(1, NS, 32'h0, 5, 8'h00));
    tv.push_back(v(0, SQ, 32'h4, 5, 8'h00));
    tv.push_back(v(0, SQ, 32'h8, 5, 8'h00));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h20));
    tv.push_back(v(1, NS, 32'h0, 5, 8'h00));
    tv.push_back(v(0, SQ, 32'h4, 5, 8'h00));
    tv.push_back(v(0, SQ, 32'h8, 5, 8'h00));
    tv.push_back(v(0, SQ, 32'hC, 5, 8'h00, 0, 1));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h00, 1, 1));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h00));
    tv.push_back(v(1, NS, 32'h200, 0, 8'h00, 0));
    tv.push_back(v(0, NS, 32'h204, 0, 8'h40));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h00));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h80, 1, 1));
    tv.push_back(v(1, NS, 32'h0, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h4, 3, 8'h10, 1, 0, 1));
    tv.push_back(v(1, NS, 32'h2, 0, 8'h01));
    tv.push_back(v(0, NS, 32'h2, 0, 8'h00, 1, 0, 0, 1));
    tv.push_back(v(1, NS, 32'h0, 1, 8'h00));
    tv.push_back(v(0, SQ, 32'h8, 1, 8'h04));
    tv.push_back(v(1, NS, 32'h0, 3, 8'h00));
    tv.push_back(v(0, BY, 32'h4, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h4, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h8, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'hC, 3, 8'h00));
    tv.push_back(v(0, ID, 32'h0, 0, 8'h00));
    tv.push_back(v(1, NS, 32'h0, 3, 8'h00));
    tv.push_back(v(0, SQ, 32'h4, 3, 8'h00));
    tv.push_back(v(1, SQ, 32'h8, 3, 8'h20));
    tv.push_back(v(1, BY, 32'h0, 1, 8'h20));
    tv.push_back(v(1, NS, 32'hFFFF_FFFC, 1, 8'h00));
    tv.push_back(v(0, SQ, 32'h0, 1, 8'h02));

    #2;
    chk("rst_pulse", err_pulse, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", err_count, 0);
    chk("rst_first", {first_valid, first_code,
        first_addr, first_master}, 0);
    do_reset();

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      htrans = tv[i].tr; haddr = tv[i].a;
      hburst = tv[i].bu; hready = tv[i].rdy;
      hresp = tv[i].rsp; hwrite = tv[i].wr;
      hsize = tv[i].sz;
      @(posedge hclk);
      #1;
      chk($sformatf("vec%0d", i), err_pulse, tv[i].exp);
    end

    do_reset();
    chk_en = 0;
    drive(NS, 32'h1, 0);
    chk("dis_pulse", err_pulse, 0);
    drive(ID, 32'h0, 0);
    chk("dis_sticky", err_sticky, 0);
    chk_en = 1;

    do_reset();
    hmaster = 4'hA;
    drive(NS, 32'h3FC, 1);
    drive(SQ, 32'h400, 1);
    chk("kb_pulse", err_pulse, 8'h02);
    hmaster = 4'h5;
    drive(ID, 32'h0, 0);
    chk("kb_valid", first_valid, 1);
    chk("kb_code", first_code, 8'h02);
    chk("kb_addr", first_addr, 32'h400);
    chk("kb_mst", first_master, 4'hA);
    drive(NS, 32'h1, 0);
    drive(ID, 32'h0, 0);
    chk("frz_code", first_code, 8'h02);
    chk("frz_mst", first_master, 4'hA);
    chk("frz_sticky", err_sticky, 8'h03);
    chk("frz_count", err_count, 2);

    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++)
      drive(NS, 32'h1, 0);
    drive(ID, 32'h0, 0);
    drive(ID, 32'h0, 0);
    chk("sat_count", err_count, 4'hF);
    chk("sat_sticky", err_sticky, 8'h01);

    drive(NS, 32'h1, 0);
    err_clr = 1;
    drive(ID, 32'h0, 0);
    err_clr = 0;
    chk("clr_sticky", err_sticky, 8'h01);
    chk("clr_count", err_count, 1);
    chk("clr_code", first_code, 8'h01);
    chk("clr_addr", first_addr, 32'h1);
    err_clr = 1;
    drive(ID, 32'h0, 0);
    err_clr = 0;
    chk("clr0", {err_sticky, 4'(err_count),
        7'(first_valid)}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
